regfile_writeback: RTL

- Writeback stage directly upstream of register_file; owns its single write port (write_reg/write_en/write_data).
- Merges results from two producers, the ALU and the load unit, each with a valid/ready handshake.
- Load results are buffered in a small FIFO; ALU results have priority, with an anti-starvation counter.
- Keeps a pending-write scoreboard for decode hazard checks.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/regfile_writeback_if.sv | 33 +++
 rtl/wb_fifo.sv | 59 +++++
 rtl/regfile_writeback.sv | 137 +++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared widths, the buffered write entry and the per-cycle arbitration result
// for the register-file writeback stage.
package wb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 64;
   localparam int NUM_REGS   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ALU_WIN  = 2'd1,
      FIFO_WIN = 2'd2
   } wb_sel_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Producer handshakes, decode issue, register-file write port and scoreboard
// of the writeback stage. slave = the writeback block, master = its environment.
interface regfile_writeback_if;
   import wb_pkg::*;

   logic                  alu_valid;
   logic                  alu_ready;
   logic [REG_ADDR_W-1:0] alu_rd;
   logic [DATA_W-1:0]     alu_data;
   logic                  mem_valid;
   logic                  mem_ready;
   logic [REG_ADDR_W-1:0] mem_rd;
   logic [DATA_W-1:0]     mem_data;
   logic                  issue_valid;
   logic [REG_ADDR_W-1:0] issue_rd;
   logic                  write_en;
   logic [REG_ADDR_W-1:0] write_reg;
   logic [DATA_W-1:0]     write_data;
   logic [NUM_REGS-1:0]   pending;

   modport master (
      output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
             issue_valid, issue_rd,
      input  alu_ready, mem_ready, write_en, write_reg, write_data, pending
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
             issue_valid, issue_rd,
      output alu_ready, mem_ready, write_en, write_reg, write_data, pending
   );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of load results with an explicit occupancy count; a push
// while full and a pop while empty are ignored.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               i_push,
   input  wb_entry_t                          i_push_data,
   input  logic                               i_pop,
   output wb_entry_t                          o_pop_data,
   output logic                               o_full,
   output logic                               o_empty,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   wb_entry_t         r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              w_do_push;
   logic              w_do_pop;

   always_comb begin
      o_full     = (r_count == CW'(FIFO_DEPTH));
      o_empty    = (r_count == {CW{1'b0}});
      w_do_push  = i_push & ~o_full;
      w_do_pop   = i_pop & ~o_empty;
      o_pop_data = r_mem[r_rd_ptr];
      o_count    = r_count;
   end

   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: ALU-priority merge of ALU and buffered load results into the
// single register-file write port, plus a pending-write scoreboard.
// Optional macro WB_ORPHAN_CHECK_EN adds a sticky orphan_err output.
module regfile_writeback
   import wb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_DEFER  = 3
) (
   input  logic              clk,
   input  logic              reset,
   regfile_writeback_if.slave bus
`ifdef WB_ORPHAN_CHECK_EN
   ,
   output logic              orphan_err
`endif
);

   localparam int DW = $clog2(MAX_DEFER + 1);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   wb_entry_t             w_alu_entry;
   wb_entry_t             w_mem_entry;
   wb_entry_t             w_fifo_head;
   logic                  w_fifo_full;
   logic                  w_fifo_empty;
   logic [CW-1:0]         w_fifo_count;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_alu_ready;
   wb_sel_t               w_sel;
   logic [DW-1:0]         w_defer_nxt;
   logic [NUM_REGS-1:0]   w_set_mask;
   logic [NUM_REGS-1:0]   w_clr_mask;

   logic [DW-1:0]         r_defer_cnt;
   logic                  r_write_en;
   logic [REG_ADDR_W-1:0] r_write_reg;
   logic [DATA_W-1:0]     r_write_data;
   logic [NUM_REGS-1:0]   r_pending;

   wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push),
      .i_push_data (w_mem_entry),
      .i_pop       (w_pop),
      .o_pop_data  (w_fifo_head),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty),
      .o_count     (w_fifo_count)
   );

   always_comb begin
      w_alu_entry = '{rd: bus.alu_rd, data: bus.alu_data};
      w_mem_entry = '{rd: bus.mem_rd, data: bus.mem_data};
      w_push      = bus.mem_valid & ~w_fifo_full;
      w_alu_ready = !(!w_fifo_empty && (r_defer_cnt == DW'(MAX_DEFER)));

      if (bus.alu_valid && w_alu_ready) begin
         w_sel = ALU_WIN;
      end else if (!w_fifo_empty) begin
         w_sel = FIFO_WIN;
      end else begin
         w_sel = IDLE;
      end
      w_pop = (w_sel == FIFO_WIN);

      // Only ALU wins that leave a load waiting count toward starvation.
      if (w_sel == FIFO_WIN || w_fifo_count == {CW{1'b0}}) begin
         w_defer_nxt = {DW{1'b0}};
      end else if (w_sel == ALU_WIN && r_defer_cnt != DW'(MAX_DEFER)) begin
         w_defer_nxt = r_defer_cnt + DW'(1);
      end else begin
         w_defer_nxt = r_defer_cnt;
      end

      w_set_mask = bus.issue_valid ? (NUM_REGS'(1) << bus.issue_rd) : {NUM_REGS{1'b0}};
      w_clr_mask = r_write_en ? (NUM_REGS'(1) << r_write_reg) : {NUM_REGS{1'b0}};
   end

   assign bus.mem_ready  = ~w_fifo_full;
   assign bus.alu_ready  = w_alu_ready;
   assign bus.write_en   = r_write_en;
   assign bus.write_reg  = r_write_reg;
   assign bus.write_data = r_write_data;
   assign bus.pending    = r_pending;

   // The winner of this cycle becomes next cycle's register-file write.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_write_en   <= 1'b0;
         r_write_reg  <= {REG_ADDR_W{1'b0}};
         r_write_data <= {DATA_W{1'b0}};
         r_defer_cnt  <= {DW{1'b0}};
      end else begin
         r_defer_cnt <= w_defer_nxt;
         case (w_sel)
            ALU_WIN: begin
               r_write_en   <= 1'b1;
               r_write_reg  <= w_alu_entry.rd;
               r_write_data <= w_alu_entry.data;
            end
            FIFO_WIN: begin
               r_write_en   <= 1'b1;
               r_write_reg  <= w_fifo_head.rd;
               r_write_data <= w_fifo_head.data;
            end
            default: r_write_en <= 1'b0;
         endcase
      end
   end

   // A new issue to the register being committed keeps it pending.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pending <= {NUM_REGS{1'b0}};
      end else begin
         r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
      end
   end

`ifdef WB_ORPHAN_CHECK_EN
   logic r_orphan_err;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_orphan_err <= 1'b0;
      end else if (r_write_en && !r_pending[r_write_reg]) begin
         r_orphan_err <= 1'b1;
      end
   end

   assign orphan_err = r_orphan_err;
`endif

endmodule
